// File: rtl/timing_gearbox_if.sv
// Frame-word valid/ready handshake feeding the timing gearbox.
interface timing_gearbox_if #(
  parameter int WORD_W = 10
);
  logic [WORD_W-1:0] in_word;
  logic              in_valid;
  logic              in_ready;

  modport master (
    output in_word,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_word,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/timing_gearbox.sv
// Frames WORD_W-bit words into OUT_W-bit line slots, filling gaps with IDLE_WORD.
// Optional PRBS7 test source is built only when TS_PRBS_EN is defined.
module timing_gearbox #(
  parameter int              WORD_W    = 10,
  parameter int              OUT_W     = 2,
  parameter logic [WORD_W-1:0] IDLE_WORD = 10'h0FA
) (
  input  logic             clk_par,
  input  logic             reset_n,
  timing_gearbox_if.slave  s_in,
  input  logic             msb_first,
  input  logic             bitslip,
  input  logic             prbs_sel,
  output logic [OUT_W-1:0] out_bits,
  output logic             out_first,
  output logic [15:0]      underflow_cnt
);
  localparam int N  = WORD_W / OUT_W;
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW-1:0] LAST = PW'(N - 1);

  if (WORD_W % OUT_W != 0) begin : g_bad_ratio
    $error("WORD_W must be a multiple of OUT_W");
  end

  logic [PW-1:0]     r_phase;
  logic [WORD_W-1:0] r_shift;
  logic [OUT_W-1:0]  r_out_bits;
  logic              r_out_first;
  logic [15:0]       r_ucnt;

  logic              w_load;
  logic              w_prbs_take;
  logic              w_xfer;
  logic [WORD_W-1:0] w_src;
  logic [WORD_W-1:0] w_ord;

  // A bitslip freezes the whole frame engine, including the load slot.
  assign w_load         = (r_phase == LAST) && !bitslip;
  assign s_in.in_ready  = w_load && !w_prbs_take;
  assign w_xfer         = s_in.in_ready && s_in.in_valid;
  assign w_src          = w_xfer ? s_in.in_word : IDLE_WORD;

`ifdef TS_PRBS_EN
  logic [6:0]        r_prbs;
  logic [6:0]        w_prbs_nxt;
  logic [WORD_W-1:0] w_prbs_word;

  assign w_prbs_take = w_load && prbs_sel;

  always_comb begin
    logic [6:0] s;
    s           = r_prbs;
    w_prbs_word = '0;
    for (int i = 0; i < WORD_W; i++) begin
      w_prbs_word[WORD_W-1-i] = s[6] ^ s[5];
      s = {s[5:0], s[6] ^ s[5]};
    end
    w_prbs_nxt = s;
  end

  always_ff @(posedge clk_par) begin
    if (!reset_n) begin
      r_prbs <= 7'h7F;
    end else if (w_prbs_take) begin
      r_prbs <= w_prbs_nxt;
    end
  end
`else
  logic w_unused;
  assign w_prbs_take = 1'b0;
  assign w_unused    = prbs_sel;
`endif

  // Word is reordered so the shifter always emits from the top down.
  always_comb begin
    w_ord = w_src;
    if (!msb_first) begin
      for (int i = 0; i < WORD_W; i++) begin
        w_ord[i] = w_src[WORD_W-1-i];
      end
    end
`ifdef TS_PRBS_EN
    if (w_prbs_take) begin
      w_ord = w_prbs_word;
    end
`endif
  end

  always_ff @(posedge clk_par) begin
    if (!reset_n) begin
      r_phase     <= LAST;
      r_shift     <= '0;
      r_out_bits  <= '0;
      r_out_first <= 1'b0;
      r_ucnt      <= '0;
    end else if (!bitslip) begin
      if (w_load) begin
        r_phase     <= '0;
        r_shift     <= w_ord << OUT_W;
        r_out_bits  <= w_ord[WORD_W-1 -: OUT_W];
        r_out_first <= 1'b1;
        if (!w_xfer && !w_prbs_take && r_ucnt != 16'hFFFF) begin
          r_ucnt <= r_ucnt + 16'd1;
        end
      end else begin
        r_phase     <= r_phase + PW'(1);
        r_shift     <= r_shift << OUT_W;
        r_out_bits  <= r_shift[WORD_W-1 -: OUT_W];
        r_out_first <= 1'b0;
      end
    end
  end

  assign out_bits      = r_out_bits;
  assign out_first     = r_out_first;
  assign underflow_cnt = r_ucnt;
endmodule

// File: tb/tb_timing_gearbox.sv
// Scoreboard bench for timing_gearbox: slot-queue reference model plus a
// separate N=1 instance that drives the underflow counter into saturation.
module tb_timing_gearbox;
  localparam int W = 10;
  localparam int O = 2;
  localparam int N = W / O;
  localparam logic [W-1:0] IDLE = 10'h0FA;
`ifdef TS_PRBS_EN
  localparam bit PRBS_EN = 1'b1;
`else
  localparam bit PRBS_EN = 1'b0;
`endif

  typedef struct packed {
    logic         rdy;
    logic [O-1:0] bits;
    logic         first;
    logic [15:0]  cnt;
  } exp_t;

  logic         clk_par   = 1'b0;
  logic         reset_n   = 1'b0;
  logic         msb_first = 1'b0;
  logic         bitslip   = 1'b0;
  logic         prbs_sel  = 1'b0;
  logic [O-1:0] out_bits;
  logic         out_first;
  logic [15:0]  underflow_cnt;

  logic         s_rst_n = 1'b0;
  logic [W-1:0] s_bits;
  logic         s_first;
  logic [15:0]  s_cnt;
  logic         sat_done = 1'b0;

  int total = 0;
  int bad   = 0;

  exp_t         sb[$];
  logic [O-1:0] mq[$];
  logic [O-1:0] m_cur;
  logic         m_first;
  logic [15:0]  m_cnt;
  logic [6:0]   m_ps;

  timing_gearbox_if #(.WORD_W(W)) m_if ();
  timing_gearbox_if #(.WORD_W(W)) s_if ();

  timing_gearbox #(.WORD_W(W), .OUT_W(O), .IDLE_WORD(IDLE)) dut (
    .clk_par       (clk_par),
    .reset_n       (reset_n),
    .s_in          (m_if),
    .msb_first     (msb_first),
    .bitslip       (bitslip),
    .prbs_sel      (prbs_sel),
    .out_bits      (out_bits),
    .out_first     (out_first),
    .underflow_cnt (underflow_cnt)
  );

  timing_gearbox #(.WORD_W(W), .OUT_W(W), .IDLE_WORD(IDLE)) u_sat (
    .clk_par       (clk_par),
    .reset_n       (s_rst_n),
    .s_in          (s_if),
    .msb_first     (1'b1),
    .bitslip       (1'b0),
    .prbs_sel      (1'b0),
    .out_bits      (s_bits),
    .out_first     (s_first),
    .underflow_cnt (s_cnt)
  );

  always #5 clk_par = ~clk_par;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [O-1:0] slot_of(input logic [W-1:0] word,
                                           input bit msb, input int s);
    logic [O-1:0] r;
    r = '0;
    if (msb) begin
      r = word[W-1-s*O -: O];
    end else begin
      for (int j = 0; j < O; j++) r[O-1-j] = word[s*O+j];
    end
    return r;
  endfunction

  function automatic logic [W-1:0] prbs_word();
    logic [W-1:0] wd;
    logic         b;
    wd = '0;
    for (int i = 0; i < W; i++) begin
      b        = m_ps[6] ^ m_ps[5];
      m_ps     = {m_ps[5:0], b};
      wd[W-1-i] = b;
    end
    return wd;
  endfunction

  // Drive one cycle of inputs and push what the line should show after it.
  task automatic cyc(input logic rst_n, input logic v, input logic [W-1:0] w,
                     input logic msb, input logic bs, input logic ps);
    exp_t         e;
    logic [W-1:0] word;
    bit           use_msb;
    @(posedge clk_par);
    #1;
    reset_n       = rst_n;
    m_if.in_valid = v;
    m_if.in_word  = w;
    msb_first     = msb;
    bitslip       = bs;
    prbs_sel      = ps;
    e.rdy = (mq.size() == 0) && !bs && !(PRBS_EN && ps);
    if (!rst_n) begin
      mq.delete();
      m_cur   = '0;
      m_first = 1'b0;
      m_cnt   = '0;
      m_ps    = 7'h7F;
    end else if (!bs) begin
      if (mq.size() == 0) begin
        use_msb = msb;
        if (PRBS_EN && ps) begin
          word    = prbs_word();
          use_msb = 1'b1;
        end else if (v) begin
          word = w;
        end else begin
          word = IDLE;
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
        m_cur   = slot_of(word, use_msb, 0);
        m_first = 1'b1;
        for (int s = 1; s < N; s++) mq.push_back(slot_of(word, use_msb, s));
      end else begin
        m_cur   = mq.pop_front();
        m_first = 1'b0;
      end
    end
    e.bits  = m_cur;
    e.first = m_first;
    e.cnt   = m_cnt;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_par);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("in_ready", 32'(m_if.in_ready), 32'(e.rdy));
        @(posedge clk_par);
        #2;
        chk("out_bits", 32'(out_bits), 32'(e.bits));
        chk("out_first", 32'(out_first), 32'(e.first));
        chk("underflow_cnt", 32'(underflow_cnt), 32'(e.cnt));
      end
    end
  end

  initial begin : sat
    s_if.in_valid = 1'b0;
    s_if.in_word  = '0;
    @(posedge clk_par);
    #1;
    s_rst_n = 1'b1;
    repeat (65534) @(posedge clk_par);
    #2;
    chk("sat_cnt_pre", 32'(s_cnt), 32'd65534);
    chk("sat_idle_word", 32'(s_bits), 32'(IDLE));
    chk("sat_first", 32'(s_first), 32'd1);
    chk("sat_ready", 32'(s_if.in_ready), 32'd1);
    repeat (6) @(posedge clk_par);
    #2;
    chk("sat_cnt_hold", 32'(s_cnt), 32'hFFFF);
    sat_done = 1'b1;
  end

  initial begin : stim
    m_if.in_valid = 1'b0;
    m_if.in_word  = '0;
    m_cur   = '0;
    m_first = 1'b0;
    m_cnt   = '0;
    m_ps    = 7'h7F;

    repeat (N) cyc(1, 1, 10'h2D5, 1, 0, 0);
    repeat (N) cyc(1, 1, 10'h2D5, 0, 0, 0);
    repeat (3 * N) cyc(1, 0, '0, 1, 0, 0);

    cyc(1, 1, 10'h1A3, 1, 0, 0);
    cyc(1, 0, '0, 1, 0, 0);
    cyc(1, 0, '0, 1, 0, 0);
    cyc(1, 0, '0, 1, 1, 0);
    repeat (2 * N + 2) cyc(1, 1, W'($urandom), 1, 0, 0);
    repeat (3) cyc(1, 1, 10'h3C1, 0, 1, 0);
    repeat (2 * N) cyc(1, 1, W'($urandom), 0, 0, 0);

    cyc(1, 1, 10'h155, 1, 0, 0);
    repeat (3) cyc(1, 1, 10'h2AA, 1, 0, 0);
    cyc(0, 1, 10'h2AA, 1, 0, 0);
    repeat (2 * N) cyc(1, 1, 10'h0F0, 1, 0, 0);

    cyc(0, 0, '0, 1, 0, 0);
    repeat (8 * N) cyc(1, 1, W'($urandom), 1, 0, 1);

    for (int i = 0; i < 2000; i++) begin
      cyc(1'($urandom_range(99) != 0), 1'($urandom_range(9) < 7),
          W'($urandom), 1'($urandom_range(1)),
          1'($urandom_range(19) == 0), 1'($urandom_range(4) == 0));
    end

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk_par);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    repeat (3) @(posedge clk_par);
    for (int i = 0; i < 70000 && !sat_done; i++) @(posedge clk_par);
    chk("sat_finished", 32'(sat_done), 32'd1);
    #5;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/timing_gearbox.md
TIMING_GEARBOX -- requirements
Module: timing_gearbox

Interface
REQ-001 Parameter WORD_W, default 10, width of the parallel frame word in bits.
REQ-002 Parameter OUT_W, default 2, bits emitted per clk_par cycle to the downstream output serializer (2 = DDR pair).
REQ-003 Parameter IDLE_WORD, default 10'h0FA (K28.5 RD-), filler word loaded when no input word is available.
REQ-004 clk_par  input  1  parallel clock; all logic is on its rising edge.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 in_word  input  WORD_W  frame word to transmit.
REQ-007 in_valid  input  1  in_word is valid.
REQ-008 in_ready  output  1  block accepts in_word this cycle.
REQ-009 msb_first  input  1  1 = emit bit WORD_W-1 first; 0 = emit bit 0 first.
REQ-010 bitslip  input  1  single-cycle pulse; delays the frame boundary by one slot.
REQ-011 prbs_sel  input  1  select PRBS7 test pattern; used only when TS_PRBS_EN is defined.
REQ-012 out_bits  output  OUT_W  current slot; out_bits[OUT_W-1] is the earlier bit on the line.
REQ-013 out_first  output  1  high while out_bits carries slot 0 of a frame.
REQ-014 underflow_cnt  output  16  count of IDLE_WORD insertions.

Function
REQ-015 WORD_W SHALL be an integer multiple of OUT_W; N = WORD_W/OUT_W slots per frame; elaboration SHALL fail otherwise.
REQ-016 A slot counter phase SHALL count 0..N-1 and wrap to 0; the cycle with phase = N-1 is the load cycle.
REQ-017 in_ready SHALL equal (phase == N-1) AND NOT bitslip AND NOT (prbs_sel, when TS_PRBS_EN is defined).
REQ-018 A transfer SHALL occur only on in_valid AND in_ready; in_word is loaded into the shift register WORD_W wide at that edge.
REQ-019 In a load cycle without a transfer, IDLE_WORD SHALL be loaded and underflow_cnt SHALL increment, saturating at 16'hFFFF.
REQ-020 A word loaded at edge k SHALL appear as slots 0..N-1 on out_bits during the N cycles following edge k. out_first SHALL be high during slot 0 only.
REQ-021 msb_first SHALL be sampled at load only. MSB-first: slot s = word[WORD_W-1-s*OUT_W -: OUT_W]. LSB-first: slot s = bits s*OUT_W..s*OUT_W+OUT_W-1, with the lowest index placed in out_bits[OUT_W-1].
REQ-022 A bitslip pulse SHALL hold phase and the shift register for one cycle, repeating the current slot. This shifts all later frames by one slot.
REQ-023 A bitslip in a load cycle SHALL postpone the load, and in_ready, by one cycle. Back-to-back bitslip pulses SHALL each add one held cycle.
REQ-024 out_bits and out_first SHALL be driven from registers with no combinational path from inputs.

Reset
REQ-025 While reset_n = 0 at an edge, the following values SHALL be set: phase <= N-1, shift register <= 0, out_bits <= 0, out_first <= 0, underflow_cnt <= 0, PRBS state <= 7'h7F.
REQ-026 Reset mid-frame SHALL discard the partial frame. in_ready SHALL be high in the first cycle after release.

Configuration
REQ-027 With macro TS_PRBS_EN defined, a PRBS7 generator (x^7+x^6+1) SHALL be present. When prbs_sel = 1 in a load cycle, the next WORD_W generator bits SHALL be loaded (first generated bit emitted first), and underflow_cnt SHALL NOT change.
REQ-028 Without TS_PRBS_EN, the generator SHALL be absent, and prbs_sel SHALL be present but ignored.

Verification (WORD_W=10, OUT_W=2, N=5)
REQ-029 The following scenario SHALL be covered: reset release, in_valid=1, in_word=10'h2D5, msb_first=1. Required response: transfer in the first cycle; out_bits = 2'b10, 11, 01, 01, 01 over the next 5 cycles; out_first high on the first.
REQ-030 The following scenario SHALL be covered: the same word with msb_first=0. Required response: out_bits = 2'b10, 10, 10, 11, 01.
REQ-031 The following scenario SHALL be covered: in_valid=0 for 3 frames. Required response: IDLE_WORD is emitted three times and underflow_cnt = 3; a 65540-frame starvation yields underflow_cnt = 16'hFFFF.
REQ-032 The following scenario SHALL be covered: bitslip pulse during slot 2. Required response: slot 2 is repeated once, the next in_ready rises 6 cycles after the previous one, and the frame period then returns to 5.
REQ-033 The following scenario SHALL be covered: reset_n low during slot 3. Required response: outputs are 0 next cycle, and the following frame starts cleanly with out_first.
REQ-034 The following scenario SHALL be covered: TS_PRBS_EN defined, prbs_sel=1. Required response: the output bit stream matches a PRBS7 reference seeded 7'h7F, in_ready stays 0, and underflow_cnt is unchanged.
